// File: rtl/coherent_mem_arbiter.sv
// Snoopy bus controller: round-robin arbitration of writebacks, coherent reads and fetches onto one RAM port.
// One IDLE cycle between transactions; every beat stalls until ramstate reports ACCESS.
module coherent_mem_arbiter #(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2,
  parameter int WORD_W      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CPUS-1:0]          iREN_i,
  input  logic [CPUS*WORD_W-1:0]   iaddr_i,
  output logic [CPUS-1:0]          iwait_o,
  output logic [CPUS*WORD_W-1:0]   iload_o,
  input  logic [CPUS-1:0]          dREN_i,
  input  logic [CPUS-1:0]          dWEN_i,
  input  logic [CPUS*WORD_W-1:0]   daddr_i,
  input  logic [CPUS*WORD_W-1:0]   dstore_i,
  output logic [CPUS-1:0]          dwait_o,
  output logic [CPUS*WORD_W-1:0]   dload_o,
  input  logic [CPUS-1:0]          cctrans_i,
  input  logic [CPUS-1:0]          ccwrite_i,
  output logic [CPUS-1:0]          ccwait_o,
  output logic [CPUS-1:0]          ccinv_o,
  output logic [CPUS*WORD_W-1:0]   ccsnoopaddr_o,
  input  logic [1:0]               ramstate_i,
  input  logic [WORD_W-1:0]        ramload_i,
  output logic                     ramREN_o,
  output logic                     ramWEN_o,
  output logic [WORD_W-1:0]        ramaddr_o,
  output logic [WORD_W-1:0]        ramstore_o
);
  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, LOAD, IFETCH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] req_q, req_d, sup_q, sup_d;
  logic [IW-1:0] rr_wb_q, rr_wb_d, rr_rd_q, rr_rd_d, rr_if_q, rr_if_d;

  logic            access, last_beat;
  logic [CPUS-1:0] rd_req, snoop_sup;
  logic [IW-1:0]   sup_pick;
  logic [WORD_W-1:0] req_daddr, req_dstore, req_iaddr, sup_daddr, sup_dstore;

  assign access     = (ramstate_i == RAM_ACCESS);
  assign last_beat  = (cnt_q == CW'(BLOCK_WORDS - 1));
  assign rd_req     = dREN_i & cctrans_i;
  assign req_daddr  = daddr_i[int'(req_q)*WORD_W +: WORD_W];
  assign req_dstore = dstore_i[int'(req_q)*WORD_W +: WORD_W];
  assign req_iaddr  = iaddr_i[int'(req_q)*WORD_W +: WORD_W];
  assign sup_daddr  = daddr_i[int'(sup_q)*WORD_W +: WORD_W];
  assign sup_dstore = dstore_i[int'(sup_q)*WORD_W +: WORD_W];

  function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] v, input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic          found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      int idx;
      idx = (int'(ptr) + i) % CPUS;
      if (!found && v[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    return (int'(g) == CPUS - 1) ? '0 : g + 1'b1;
  endfunction

  // The requester's own cctrans is its request, not a supply answer.
  always_comb begin
    snoop_sup        = cctrans_i;
    snoop_sup[req_q] = 1'b0;
    sup_pick         = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (snoop_sup[j]) sup_pick = IW'(j);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      sup_q   <= '0;
      rr_wb_q <= '0;
      rr_rd_q <= '0;
      rr_if_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      sup_q   <= sup_d;
      rr_wb_q <= rr_wb_d;
      rr_rd_q <= rr_rd_d;
      rr_if_q <= rr_if_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    sup_d   = sup_q;
    rr_wb_d = rr_wb_q;
    rr_rd_d = rr_rd_q;
    rr_if_d = rr_if_q;
    case (state_q)
      IDLE: begin
        if (|dWEN_i) begin
          req_d   = rr_pick(dWEN_i, rr_wb_q);
          rr_wb_d = rr_next(req_d);
          state_d = WB;
        end else if (|rd_req) begin
          req_d   = rr_pick(rd_req, rr_rd_q);
          rr_rd_d = rr_next(req_d);
          state_d = SNOOP;
        end else if (|iREN_i) begin
          req_d   = rr_pick(iREN_i, rr_if_q);
          rr_if_d = rr_next(req_d);
          state_d = IFETCH;
        end
      end
      SNOOP: begin
        if (|snoop_sup) begin
          sup_d   = sup_pick;
          state_d = C2C;
        end else begin
          state_d = LOAD;
        end
      end
      WB, C2C, LOAD: begin
        if (access) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      IFETCH: begin
        if (access) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iwait_o       = '1;
    dwait_o       = '1;
    iload_o       = '0;
    dload_o       = '0;
    ccwait_o      = '0;
    ccinv_o       = '0;
    ccsnoopaddr_o = '0;
    ramREN_o      = 1'b0;
    ramWEN_o      = 1'b0;
    ramaddr_o     = '0;
    ramstore_o    = '0;
    case (state_q)
      WB: begin
        ramWEN_o       = 1'b1;
        ramaddr_o      = req_daddr;
        ramstore_o     = req_dstore;
        dwait_o[req_q] = !access;
      end
      SNOOP, C2C, LOAD: begin
        for (int j = 0; j < CPUS; j++) begin
          if (j != int'(req_q)) begin
            ccwait_o[j] = 1'b1;
            ccinv_o[j]  = ccwrite_i[req_q];
            if (state_q != LOAD) ccsnoopaddr_o[j*WORD_W +: WORD_W] = req_daddr;
          end
        end
        if (state_q == C2C) begin
          ramWEN_o                              = 1'b1;
          ramaddr_o                             = sup_daddr;
          ramstore_o                            = sup_dstore;
          dload_o[int'(req_q)*WORD_W +: WORD_W] = sup_dstore;
          dwait_o[req_q]                        = !access;
          dwait_o[sup_q]                        = !access;
        end else if (state_q == LOAD) begin
          ramREN_o                              = 1'b1;
          ramaddr_o                             = req_daddr;
          dload_o[int'(req_q)*WORD_W +: WORD_W] = ramload_i;
          dwait_o[req_q]                        = !access;
        end
      end
      IFETCH: begin
        ramREN_o                              = 1'b1;
        ramaddr_o                             = req_iaddr;
        iload_o[int'(req_q)*WORD_W +: WORD_W] = ramload_i;
        iwait_o[req_q]                        = !access;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// Randomised transactions on a 2-core instance against a transaction-level model, plus a reset-abort run on a 4-core instance.
module tb_coherent_mem_arbiter;
  localparam int NA = 2, BA = 2, NB = 4, BB = 4;
  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACC = 2'd2, R_ERR = 2'd3;
  localparam int K_NONE = 0, K_WB = 1, K_RD = 2, K_IF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na, rst_nb;
  logic [NA-1:0] a_iREN, a_dREN, a_dWEN, a_cctrans, a_ccwrite, a_iwait, a_dwait, a_ccwait, a_ccinv;
  logic [NA*32-1:0] a_iaddr, a_iload, a_daddr, a_dstore, a_dload, a_ccsnoopaddr;
  logic [1:0] a_ramstate;
  logic [31:0] a_ramload, a_ramaddr, a_ramstore;
  logic a_ramREN, a_ramWEN;

  logic [NB-1:0] b_iREN, b_dREN, b_dWEN, b_cctrans, b_ccwrite, b_iwait, b_dwait, b_ccwait, b_ccinv;
  logic [NB*32-1:0] b_iaddr, b_iload, b_daddr, b_dstore, b_dload, b_ccsnoopaddr;
  logic [1:0] b_ramstate;
  logic [31:0] b_ramload, b_ramaddr, b_ramstore;
  logic b_ramREN, b_ramWEN;

  int passed = 0, total = 0;
  int rr_wb = 0, rr_rd = 0, rr_if = 0, last_req = 0;

  coherent_mem_arbiter #(.CPUS(NA), .BLOCK_WORDS(BA), .WORD_W(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_na),
    .iREN_i(a_iREN), .iaddr_i(a_iaddr), .iwait_o(a_iwait), .iload_o(a_iload),
    .dREN_i(a_dREN), .dWEN_i(a_dWEN), .daddr_i(a_daddr), .dstore_i(a_dstore),
    .dwait_o(a_dwait), .dload_o(a_dload),
    .cctrans_i(a_cctrans), .ccwrite_i(a_ccwrite), .ccwait_o(a_ccwait), .ccinv_o(a_ccinv),
    .ccsnoopaddr_o(a_ccsnoopaddr),
    .ramstate_i(a_ramstate), .ramload_i(a_ramload), .ramREN_o(a_ramREN), .ramWEN_o(a_ramWEN),
    .ramaddr_o(a_ramaddr), .ramstore_o(a_ramstore));

  coherent_mem_arbiter #(.CPUS(NB), .BLOCK_WORDS(BB), .WORD_W(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_nb),
    .iREN_i(b_iREN), .iaddr_i(b_iaddr), .iwait_o(b_iwait), .iload_o(b_iload),
    .dREN_i(b_dREN), .dWEN_i(b_dWEN), .daddr_i(b_daddr), .dstore_i(b_dstore),
    .dwait_o(b_dwait), .dload_o(b_dload),
    .cctrans_i(b_cctrans), .ccwrite_i(b_ccwrite), .ccwait_o(b_ccwait), .ccinv_o(b_ccinv),
    .ccsnoopaddr_o(b_ccsnoopaddr),
    .ramstate_i(b_ramstate), .ramload_i(b_ramload), .ramREN_o(b_ramREN), .ramWEN_o(b_ramWEN),
    .ramaddr_o(b_ramaddr), .ramstore_o(b_ramstore));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NA-1:0] oh(input int i);
    logic [NA-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // First set bit at or after ptr, cyclically; -1 if none.
  function automatic int pick(input logic [NA-1:0] v, input int ptr);
    for (int i = 0; i < NA; i++) begin
      if (v[(ptr + i) % NA]) return (ptr + i) % NA;
    end
    return -1;
  endfunction

  function automatic logic [1:0] stall_st(input int nst);
    int r;
    if (nst >= 0) return R_BUSY;
    r = $urandom_range(0, 2);
    return (r == 0) ? R_FREE : (r == 1) ? R_BUSY : R_ERR;
  endfunction

  task automatic present(input logic [31:0] fix, input int c);
    a_iaddr[c*32 +: 32]  = (fix != 0) ? fix : $urandom;
    a_daddr[c*32 +: 32]  = (fix != 0) ? fix : $urandom;
    a_dstore[c*32 +: 32] = $urandom;
  endtask

  task automatic run_txn(input logic [NA-1:0] dwen, input logic [NA-1:0] dren, input logic [NA-1:0] cct,
                         input logic [NA-1:0] iren, input logic [NA-1:0] ccw, input logic [NA-1:0] supply,
                         input int nst, input logic [31:0] fix);
    int kind, req, sup, nb, st;
    logic acc;
    logic [NA-1:0] rd, e, e2, inv, all1, others;
    logic [NA*32-1:0] esnoop;
    all1 = '1;
    a_dWEN = dwen; a_dREN = dren; a_cctrans = cct; a_iREN = iren; a_ccwrite = ccw;
    a_ramstate = R_FREE;
    a_ramload = $urandom;
    for (int c = 0; c < NA; c++) present(fix, c);
    #1;
    chk("idle_iwait", a_iwait, all1);
    chk("idle_dwait", a_dwait, all1);
    chk("idle_ren", a_ramREN, 1'b0);
    chk("idle_wen", a_ramWEN, 1'b0);
    chk("idle_ccwait", a_ccwait, 2'b00);
    chk("idle_ramaddr", a_ramaddr, 32'h0);

    rd = dren & cct;
    kind = K_NONE; req = 0; sup = -1;
    if (|dwen) begin
      kind = K_WB; req = pick(dwen, rr_wb); rr_wb = (req + 1) % NA;
    end else if (|rd) begin
      kind = K_RD; req = pick(rd, rr_rd); rr_rd = (req + 1) % NA;
    end else if (|iren) begin
      kind = K_IF; req = pick(iren, rr_if); rr_if = (req + 1) % NA;
    end
    last_req = req;
    tick();
    if (kind == K_NONE) return;

    others = ~oh(req);
    esnoop = '0;
    if (kind == K_RD) begin
      for (int c = 0; c < NA; c++) if (c != req) a_cctrans[c] = supply[c];
      a_ramstate = 2'($urandom_range(0, 3));
      #1;
      inv = a_ccwrite[req] ? others : '0;
      for (int c = 0; c < NA; c++) if (c != req) esnoop[c*32 +: 32] = a_daddr[req*32 +: 32];
      chk("snoop_ccwait", a_ccwait, others);
      chk("snoop_ccinv", a_ccinv, inv);
      chk("snoop_addr", a_ccsnoopaddr, esnoop);
      chk("snoop_ren", a_ramREN, 1'b0);
      chk("snoop_wen", a_ramWEN, 1'b0);
      chk("snoop_dwait", a_dwait, all1);
      sup = pick(supply & others, 0);
      tick();
    end

    nb = (kind == K_IF) ? 1 : BA;
    for (int b = 0; b < nb; b++) begin
      st = (nst >= 0) ? nst : $urandom_range(0, 2);
      for (int s = 0; s <= st; s++) begin
        acc = (s == st);
        a_ramstate = acc ? R_ACC : stall_st(nst);
        a_ramload = $urandom;
        present(fix, req);
        if (sup >= 0) present(fix, sup);
        if (kind == K_IF) a_dWEN = NA'($urandom);
        #1;
        e = acc ? others : all1;
        case (kind)
          K_WB: begin
            chk("wb_wen", a_ramWEN, 1'b1);
            chk("wb_ren", a_ramREN, 1'b0);
            chk("wb_addr", a_ramaddr, a_daddr[req*32 +: 32]);
            chk("wb_data", a_ramstore, a_dstore[req*32 +: 32]);
            chk("wb_dwait", a_dwait, e);
            chk("wb_iwait", a_iwait, all1);
          end
          K_IF: begin
            chk("if_ren", a_ramREN, 1'b1);
            chk("if_wen", a_ramWEN, 1'b0);
            chk("if_addr", a_ramaddr, a_iaddr[req*32 +: 32]);
            chk("if_iwait", a_iwait, e);
            chk("if_dwait", a_dwait, all1);
            if (acc) chk("if_iload", a_iload[req*32 +: 32], a_ramload);
          end
          default: begin
            inv = a_ccwrite[req] ? others : '0;
            chk("rd_ccwait", a_ccwait, others);
            chk("rd_ccinv", a_ccinv, inv);
            if (sup >= 0) begin
              e2 = acc ? ~(oh(req) | oh(sup)) : all1;
              for (int c = 0; c < NA; c++) if (c != req) esnoop[c*32 +: 32] = a_daddr[req*32 +: 32];
              chk("c2c_wen", a_ramWEN, 1'b1);
              chk("c2c_ren", a_ramREN, 1'b0);
              chk("c2c_addr", a_ramaddr, a_daddr[sup*32 +: 32]);
              chk("c2c_data", a_ramstore, a_dstore[sup*32 +: 32]);
              chk("c2c_dwait", a_dwait, e2);
              chk("c2c_snoopaddr", a_ccsnoopaddr, esnoop);
              if (acc) chk("c2c_dload", a_dload[req*32 +: 32], a_dstore[sup*32 +: 32]);
            end else begin
              chk("ld_ren", a_ramREN, 1'b1);
              chk("ld_wen", a_ramWEN, 1'b0);
              chk("ld_addr", a_ramaddr, a_daddr[req*32 +: 32]);
              chk("ld_dwait", a_dwait, e);
              if (acc) chk("ld_dload", a_dload[req*32 +: 32], a_ramload);
            end
          end
        endcase
        tick();
      end
    end
  endtask

  initial begin
    logic [NA-1:0] rem;
    rst_na = 1'b0; rst_nb = 1'b0;
    a_iREN = '0; a_dREN = '0; a_dWEN = '0; a_cctrans = '0; a_ccwrite = '0;
    a_iaddr = '0; a_daddr = '0; a_dstore = '0; a_ramstate = R_FREE; a_ramload = '0;
    b_iREN = '0; b_dREN = '0; b_dWEN = '0; b_cctrans = '0; b_ccwrite = '0;
    b_iaddr = '0; b_daddr = '0; b_dstore = '0; b_ramstate = R_FREE; b_ramload = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iwait", a_iwait, 2'b11);
    chk("rst_dwait", a_dwait, 2'b11);
    chk("rst_ren_wen", {a_ramREN, a_ramWEN}, 2'b00);
    chk("rst_cc", {a_ccwait, a_ccinv}, 4'h0);
    rst_na = 1'b1; rst_nb = 1'b1;
    #1;
    chk("post_rst_loads", {a_iload, a_dload}, 128'h0);
    chk("post_rst_ram", {a_ramaddr, a_ramstore}, 64'h0);
    chk("post_rst_snoopaddr", a_ccsnoopaddr, 64'h0);
    chk("post_rst_b_dwait", b_dwait, 4'hf);

    // Fetch with two BUSY cycles, miss with no supplier, read-exclusive served cache-to-cache.
    run_txn(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2, 32'h40);
    run_txn(2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, -1, 32'h100);
    run_txn(2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, -1, 32'h200);
    for (int k = 0; k < 4; k++) run_txn(2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, -1, 32'h0);
    run_txn(2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, -1, 32'h0);
    rem = 2'b11 & ~oh(last_req);
    run_txn(rem, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, -1, 32'h0);
    run_txn(2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, -1, 32'h0);
    for (int t = 0; t < 60; t++)
      run_txn(NA'($urandom), NA'($urandom), NA'($urandom), NA'($urandom), NA'($urandom),
              NA'($urandom), -1, 32'h0);
    a_dWEN = '0; a_dREN = '0; a_iREN = '0; a_cctrans = '0;

    // Core 3 writeback aborted by reset after two beats, then a full four-beat writeback.
    b_dWEN = 4'b1000;
    b_daddr[3*32 +: 32] = 32'h300;
    b_dstore[3*32 +: 32] = 32'hCAFE0003;
    #1;
    chk("b_idle_dwait", b_dwait, 4'hf);
    tick();
    for (int k = 0; k < 2; k++) begin
      b_ramstate = R_ACC;
      #1;
      chk("b_beat_wen", b_ramWEN, 1'b1);
      chk("b_beat_dwait", b_dwait, 4'b0111);
      chk("b_beat_addr", b_ramaddr, 32'h300);
      tick();
    end
    b_ramstate = R_BUSY;
    #1;
    chk("b_pre_rst_wen", b_ramWEN, 1'b1);
    rst_nb = 1'b0;
    #1;
    chk("b_rst_wen", b_ramWEN, 1'b0);
    chk("b_rst_dwait", b_dwait, 4'hf);
    chk("b_rst_ram", {b_ramaddr, b_ramstore}, 64'h0);
    chk("b_rst_cc", {b_ccwait, b_ccinv}, 8'h0);
    tick();
    rst_nb = 1'b1;
    b_ramstate = R_FREE;
    #1;
    chk("b_after_rst_wen", b_ramWEN, 1'b0);
    tick();
    for (int k = 0; k < BB; k++) begin
      b_ramstate = R_ACC;
      #1;
      chk("b_full_wen", b_ramWEN, 1'b1);
      chk("b_full_dwait", b_dwait, 4'b0111);
      tick();
    end
    b_dWEN = '0;
    b_ramstate = R_FREE;
    #1;
    chk("b_end_wen", b_ramWEN, 1'b0);
    chk("b_end_dwait", b_dwait, 4'hf);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/coherent_mem_arbiter.md
Name: coherent_mem_arbiter

Overview:
- Parametrised snoopy-coherence bus controller and RAM arbiter for a CPUS-core system. Each core has one icache and one dcache port.
- Sits between the per-core cache controllers and the single-ported RAM model.
- Serialises instruction fetches, dcache writebacks and coherent dcache reads, with fair round-robin arbitration.
- Supports cache-to-cache block transfers of BLOCK_WORDS words; memory is updated during every transfer.

Parameters:
CPUS, 2, number of cores/cache pairs (2..8)
BLOCK_WORDS, 2, words per cache block moved per transaction (1..8)
WORD_W, 32, data/address width (word_t)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  CPUS  icache read request per core
iaddr  in  CPUS*WORD_W  icache address per core
iwait  out  CPUS  icache stall, low for the cycle data is valid
iload  out  CPUS*WORD_W  icache read data
dREN  in  CPUS  dcache read (miss fill) request
dWEN  in  CPUS  dcache writeback request
daddr  in  CPUS*WORD_W  dcache address per core
dstore  in  CPUS*WORD_W  dcache write / snoop-supply data
dwait  out  CPUS  dcache stall
dload  out  CPUS*WORD_W  dcache read data
cctrans  in  CPUS  core starting coherent transaction / snooper supplying dirty block
ccwrite  in  CPUS  requester intends to write (read-exclusive)
ccwait  out  CPUS  core is being snooped; must hold and answer
ccinv  out  CPUS  invalidate snooped block
ccsnoopaddr  out  CPUS*WORD_W  address being snooped
ramstate  in  2  ramstate_t: FREE/BUSY/ACCESS/ERROR
ramload  in  WORD_W  RAM read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data

Behaviour:
- Reset (async, any state): state=IDLE, word counter=0, all three rr pointers=0.
- Output defaults (reset and every idle cycle): iwait/dwait all 1; iload, dload, ramaddr, ramstore, ccsnoopaddr all 0; ramREN, ramWEN, ccwait, ccinv all 0.
- A beat completes on a cycle with ramstate==ACCESS. BUSY, FREE and ERROR all stall; there is no timeout.
- The counter increments per completed beat. The transaction ends on the beat where the counter is BLOCK_WORDS-1; the counter then clears and the FSM returns to IDLE. The cache presents each beat's address.
- Class priority, evaluated in IDLE only: dWEN > (dREN & cctrans) > iREN.
- Within a class, grant the first requester at or after that class's rr pointer, modulo CPUS. On grant, that pointer = grantee+1 (wraps at CPUS).
- The grantee is latched as req and is fixed for the whole transaction.
- States:
  - IDLE -> WB | SNOOP | IFETCH.
  - WB: ramWEN=1; ramaddr/ramstore = daddr/dstore[req]; dwait[req] = !ACCESS.
  - SNOOP (exactly 1 cycle): ccwait[j]=1 and ccsnoopaddr[j]=daddr[req] for all j!=req; ccinv[j] = ccwrite[req].
    - Next cycle -> C2C if any snooper j!=req has cctrans[j]=1. sup = lowest such index.
    - Otherwise -> LOAD.
  - C2C:
    - ramWEN=1; ramaddr=daddr[sup]; ramstore=dstore[sup]; dload[req]=dstore[sup].
    - dwait[req] = dwait[sup] = !ACCESS.
    - ccwait and ccsnoopaddr stay held to all j!=req; ccinv held.
  - LOAD:
    - ramREN=1; ramaddr=daddr[req]; dload[req]=ramload; dwait[req] = !ACCESS.
    - Snoopers keep ccwait=1; ccinv held.
  - IFETCH:
    - Single beat regardless of BLOCK_WORDS. ramREN=1; ramaddr=iaddr[req]; iload[req]=ramload; iwait[req] = !ACCESS.
    - An arriving dWEN does not preempt IFETCH.
- Requests are sampled only in IDLE, so one idle cycle separates transactions.
- Simultaneous dREN&cctrans from two cores: one wins by rr; the loser stays stalled with dwait=1 and is snooped as normal during the winner's transaction.
- ramREN and ramWEN are never both 1.
- At most one core has iwait=0 or dwait=0 in a cycle, except the req/sup pair in C2C.
- A requester dropping its request mid-transaction is a protocol violation; the FSM still completes the beat count.

Test Plan:
- CPUS=2, BLOCK_WORDS=2: core0 iREN, iaddr=0x40, RAM gives ACCESS after 2 BUSY cycles with ramload=0xDEAD -> iwait[0]=0 and iload[0]=0xDEAD on the ACCESS cycle only; iwait[1]=1 throughout.
- Core0 dREN+cctrans, daddr=0x100; core1 answers cctrans=0 -> ccwait[1]=1 and ccsnoopaddr[1]=0x100 during SNOOP; then two ramREN beats and dwait[0] low twice.
- Core1 dREN+cctrans+ccwrite, addr 0x200; core0 answers cctrans=1 with dstore=0xBEEF -> ccinv[0]=1; C2C with ramWEN=1, dload[1]=0xBEEF, dwait[0]=dwait[1]=0 on each ACCESS.
- Both cores hold iREN continuously -> grants alternate 0,1,0,1; both cores assert dWEN together with iREN -> both writebacks served before any fetch.
- CPUS=4, BLOCK_WORDS=4: core3 writeback, assert nRST low after beat 2 -> all outputs return to defaults immediately, counter=0; the next transaction runs 4 full beats.
